mac_feed: RTL

- Upstream feeder for the sequential square-root stage.
- Computes x = sat8(a*b + c) using a multi-cycle shift-add multiplier.
- Delivers x to the sqrt stage through its start/busy handshake: drives ds_start_o and ds_x_o, and watches the sqrt stage's 2-bit busy code.
- One operation in flight; new requests are accepted only while the block is idle.

---
 rtl/mac_feed_pkg.sv | 16 +
 rtl/shift_add_mul.sv | 46 ++++
 rtl/mac_feed.sv | 106 ++++++++++
 3 files changed

// File: rtl/mac_feed_pkg.sv
// Shared constants for the MAC feeder: FSM state codes and the sqrt-stage
// handshake and saturation constants.
package mac_feed_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StMul    = 3'd1,
      StAdd    = 3'd2,
      StWaitDs = 3'd3,
      StIssue  = 3'd4
   } state_e;

   localparam logic [1:0] DS_IDLE = 2'b00;
   localparam logic [7:0] SAT_MAX = 8'hFF;

endpackage

// File: rtl/shift_add_mul.sv
// Sequential shift-add multiplier: one multiplier bit per step, AB_W steps per product.
module shift_add_mul #(
   parameter int unsigned AB_W  = 4,
   parameter int unsigned CNT_W = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic                  step_i,
   input  logic [AB_W-1:0]       a_i,
   input  logic [AB_W-1:0]       b_i,
   output logic [2*AB_W-1:0]     acc_o,
   output logic                  done_o
);

   logic [2*AB_W-1:0] acc_q;
   logic [2*AB_W-1:0] mcand_q;
   logic [AB_W-1:0]   mplier_q;
   logic [CNT_W-1:0]  cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else if (load_i) begin
         acc_q    <= '0;
         mcand_q  <= {{AB_W{1'b0}}, a_i};
         mplier_q <= b_i;
         cnt_q    <= '0;
      end else if (step_i) begin
         // Product fits in 2*AB_W bits, so the accumulate never overflows.
         if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
         end
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CNT_W'(1);
      end
   end

   assign acc_o  = acc_q;
   assign done_o = (cnt_q == CNT_W'(AB_W - 1));

endmodule

// File: rtl/mac_feed.sv
// Computes sat(a*b + c) and hands the result to the sqrt stage through its
// start/busy handshake. One job in flight; requests are taken only when idle.
module mac_feed
   import mac_feed_pkg::*;
#(
   parameter int unsigned AB_W  = 4,
   parameter int unsigned CNT_W = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [AB_W-1:0]       a_i,
   input  logic [AB_W-1:0]       b_i,
   input  logic [2*AB_W-1:0]     c_i,
   output logic                  busy_o,
   output logic                  sat_o,
   input  logic [1:0]            ds_busy_i,
   output logic                  ds_start_o,
   output logic [2*AB_W-1:0]     ds_x_o
);

   localparam int unsigned X_W = 2 * AB_W;

   state_e         state_q;
   logic           busy_q;
   logic           ds_start_q;
   logic           sat_q;
   logic [X_W-1:0] ds_x_q;
   logic [X_W-1:0] c_q;
   logic [X_W-1:0] acc;
   logic [X_W:0]   sum9;
   logic           mul_load;
   logic           mul_step;
   logic           mul_done;

   assign mul_load = (state_q == StIdle) && start_i;
   assign mul_step = (state_q == StMul);
   assign sum9     = {1'b0, acc} + {1'b0, c_q};

   shift_add_mul #(
      .AB_W  (AB_W),
      .CNT_W (CNT_W)
   ) u_mul (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (mul_load),
      .step_i (mul_step),
      .a_i    (a_i),
      .b_i    (b_i),
      .acc_o  (acc),
      .done_o (mul_done)
   );

   // Outputs are registered on the transition into the state that owns them.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         busy_q     <= 1'b0;
         ds_start_q <= 1'b0;
         sat_q      <= 1'b0;
         ds_x_q     <= '0;
         c_q        <= '0;
      end else begin
         ds_start_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  c_q     <= c_i;
                  busy_q  <= 1'b1;
                  state_q <= StMul;
               end
            end
            StMul: begin
               if (mul_done) begin
                  state_q <= StAdd;
               end
            end
            StAdd: begin
               ds_x_q  <= sum9[X_W] ? X_W'(SAT_MAX) : sum9[X_W-1:0];
               sat_q   <= sum9[X_W];
               state_q <= StWaitDs;
            end
            StWaitDs: begin
               if (ds_busy_i == DS_IDLE) begin
                  ds_start_q <= 1'b1;
                  state_q    <= StIssue;
               end
            end
            StIssue: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy_o     = busy_q;
   assign ds_start_o = ds_start_q;
   assign sat_o      = sat_q;
   assign ds_x_o     = ds_x_q;

endmodule
